// File: rtl/l2_port_arbiter_pkg.sv
// Shared types and helpers for the L2 port arbiter: FSM state encoding,
// default block width and a constant-friendly ceil(log2) helper.
package l2_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int BLOCK_WORDS_DEF = 16;
    localparam int BLK             = BLOCK_WORDS_DEF * DATA_WIDTH_DEF;

    // Index width for a count of 'value' items; never narrower than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/l2_port_arbiter_if.sv
// Bundle of the L1-side request/response lanes and the L2 port.
// master = the arbiter, slave = the surrounding L1 caches and L2 cache.
interface l2_port_arbiter_if #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_WORDS = 16
);
    localparam int BLK_BITS = BLOCK_WORDS * DATA_WIDTH;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*BLK_BITS-1:0]   req_wdata;
    logic [NUM_REQ-1:0]            req_ack;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [BLK_BITS-1:0]           resp_rdata;
    logic                          resp_hit;
    logic [ADDR_WIDTH-1:0]         l2_cache_addr;
    logic [BLK_BITS-1:0]           l2_cache_data_in;
    logic                          l2_cache_read;
    logic                          l2_cache_write;
    logic [BLK_BITS-1:0]           l2_cache_data_out;
    logic                          l2_cache_ready;
    logic                          l2_hit;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  l2_cache_data_out, l2_cache_ready, l2_hit,
        output req_ack, resp_valid, resp_rdata, resp_hit,
        output l2_cache_addr, l2_cache_data_in, l2_cache_read, l2_cache_write
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output l2_cache_data_out, l2_cache_ready, l2_hit,
        input  req_ack, resp_valid, resp_rdata, resp_hit,
        input  l2_cache_addr, l2_cache_data_in, l2_cache_read, l2_cache_write
    );

endinterface

// File: rtl/l2_port_arbiter_rr_grant.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_grant
    import l2_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [clog2(N)-1:0]  ptr,
    output logic [N-1:0]         gnt,
    output logic [clog2(N)-1:0]  gnt_idx,
    output logic                 any
);
    localparam int IW = clog2(N);

    // Scan from ptr upward; the first pending slot wins and masks the rest.
    always_comb begin
        logic hit_s;
        int   pos_s;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        hit_s   = 1'b0;
        pos_s   = 0;
        for (int k = 0; k < N; k++) begin
            pos_s      = (int'(ptr) + k) % N;
            hit_s      = req[pos_s] & ~any;
            gnt[pos_s] = hit_s;
            gnt_idx    = hit_s ? IW'(pos_s) : gnt_idx;
            any        = any | hit_s;
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 request port among NUM_REQ L1 requesters: round-robin grant,
// one transaction in flight, strobe/ready sequencing and response routing.
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_WORDS = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                clk,
    input  logic                rst,
    l2_port_arbiter_if.master   bus,
    output logic                busy,
    output logic                timeout_err
);
    localparam int BLK_BITS = BLOCK_WORDS * DATA_WIDTH;
    localparam int IW       = clog2(NUM_REQ);
    localparam int CW       = clog2(TIMEOUT + 1);

    state_t                 state_r;
    logic [IW-1:0]          rr_ptr_r;
    logic [IW-1:0]          cur_r;
    logic                   wr_r;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [BLK_BITS-1:0]    wdata_r;
    logic [NUM_REQ-1:0]     req_ack_r;
    logic [NUM_REQ-1:0]     resp_valid_r;
    logic [BLK_BITS-1:0]    rdata_r;
    logic                   hit_r;
    logic                   rd_stb_r;
    logic                   wr_stb_r;
    logic [CW-1:0]          cnt_r;
    logic                   terr_r;

    logic [NUM_REQ-1:0]     gnt_s;
    logic [IW-1:0]          gnt_idx_s;
    logic                   any_s;
    logic [NUM_REQ-1:0]     owner_oh_s;
    logic [IW-1:0]          next_ptr_s;
    logic                   tmo_s;

    rr_grant #(.N(NUM_REQ)) u_rr_grant (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

    assign owner_oh_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << cur_r;
    assign next_ptr_s = (cur_r == IW'(NUM_REQ - 1)) ? '0 : cur_r + IW'(1);
    // Fires on the wait cycle that would bring the spent-cycle count to TIMEOUT.
    assign tmo_s      = (cnt_r == CW'(TIMEOUT - 1));

    // Transaction FSM with latched request, strobes, response and timeout state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            rr_ptr_r     <= '0;
            cur_r        <= '0;
            wr_r         <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= '0;
            req_ack_r    <= '0;
            resp_valid_r <= '0;
            rdata_r      <= '0;
            hit_r        <= 1'b0;
            rd_stb_r     <= 1'b0;
            wr_stb_r     <= 1'b0;
            cnt_r        <= '0;
            terr_r       <= 1'b0;
        end else begin
            req_ack_r    <= '0;
            resp_valid_r <= '0;
            rd_stb_r     <= 1'b0;
            wr_stb_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        cur_r     <= gnt_idx_s;
                        wr_r      <= bus.req_write[gnt_idx_s];
                        addr_r    <= bus.req_addr[int'(gnt_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_r   <= bus.req_wdata[int'(gnt_idx_s)*BLK_BITS +: BLK_BITS];
                        req_ack_r <= gnt_s;
                        state_r   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.l2_cache_ready) begin
                        rd_stb_r <= ~wr_r;
                        wr_stb_r <= wr_r;
                        cnt_r    <= '0;
                        state_r  <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (tmo_s) begin
                        terr_r       <= 1'b1;
                        hit_r        <= 1'b0;
                        resp_valid_r <= owner_oh_s;
                        rr_ptr_r     <= next_ptr_s;
                        state_r      <= IDLE;
                    end else if (!bus.l2_cache_ready) begin
                        state_r <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (bus.l2_cache_ready) begin
                        rdata_r      <= bus.l2_cache_data_out;
                        hit_r        <= bus.l2_hit;
                        resp_valid_r <= owner_oh_s;
                        state_r      <= RESP;
                    end else if (tmo_s) begin
                        terr_r       <= 1'b1;
                        hit_r        <= 1'b0;
                        resp_valid_r <= owner_oh_s;
                        rr_ptr_r     <= next_ptr_s;
                        state_r      <= IDLE;
                    end
                end
                RESP: begin
                    rr_ptr_r <= next_ptr_s;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ack          = req_ack_r;
    assign bus.resp_valid       = resp_valid_r;
    assign bus.resp_rdata       = rdata_r;
    assign bus.resp_hit         = hit_r;
    assign bus.l2_cache_addr    = addr_r;
    assign bus.l2_cache_data_in = wdata_r;
    assign bus.l2_cache_read    = rd_stb_r;
    assign bus.l2_cache_write   = wr_stb_r;
    assign busy                 = (state_r != IDLE);
    assign timeout_err          = terr_r;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter with a small L2 model: ready drops for
// three cycles after each strobe, read data word j = (addr << 6) + j, hit = addr[6].
module tb_l2_port_arbiter;
    localparam int NR   = 2;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int BW   = 16;
    localparam int BLKB = BW * DW;
    localparam int TMO  = 8;
    localparam int LAT  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic timeout_err;

    l2_port_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_WORDS(BW)) bus ();

    l2_port_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_WORDS(BW), .TIMEOUT(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic          stuck     = 1'b0;
    int            l2_cnt    = 0;
    logic [AW-1:0] l2_addr_q = '0;
    logic [DW-1:0] cap_w5    = '0;
    int            rd_pulses = 0;
    int            wr_pulses = 0;

    // L2 model: accepts a strobe, holds ready low LAT cycles, then raises it unless stuck.
    always @(posedge clk) begin
        if (rst) begin
            l2_cnt             <= 0;
            bus.l2_cache_ready <= 1'b1;
            l2_addr_q          <= '0;
        end else if (bus.l2_cache_read || bus.l2_cache_write) begin
            l2_cnt             <= LAT - 1;
            bus.l2_cache_ready <= 1'b0;
            l2_addr_q          <= bus.l2_cache_addr;
            cap_w5             <= bus.l2_cache_data_in[5*DW +: DW];
            rd_pulses          <= rd_pulses + (bus.l2_cache_read ? 1 : 0);
            wr_pulses          <= wr_pulses + (bus.l2_cache_write ? 1 : 0);
        end else if (l2_cnt > 0) begin
            l2_cnt <= l2_cnt - 1;
        end else begin
            bus.l2_cache_ready <= !stuck;
        end
    end

    // L2 read data pattern derived from the captured address.
    always_comb begin
        bus.l2_cache_data_out = '0;
        for (int j = 0; j < BW; j++) begin
            bus.l2_cache_data_out[j*DW +: DW] = (l2_addr_q << 6) + 32'(j);
        end
        bus.l2_hit = l2_addr_q[6];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int who, input logic wr, input logic [AW-1:0] addr,
                           output logic [1:0] ack_seen, output logic [1:0] resp_seen,
                           output int lat);
        bus.req_write[who]         = wr;
        bus.req_addr[who*AW +: AW] = addr;
        bus.req_valid[who]         = 1'b1;
        lat       = 0;
        ack_seen  = '0;
        resp_seen = '0;
        while (lat < 20 && ack_seen == 2'b00) begin
            @(negedge clk);
            lat++;
            ack_seen = bus.req_ack;
        end
        bus.req_valid[who] = 1'b0;
        while (lat < 200 && resp_seen == 2'b00) begin
            @(negedge clk);
            lat++;
            resp_seen = bus.resp_valid;
        end
    endtask

    typedef struct {
        logic [1:0]  rv;
        logic [1:0]  ack;
        logic [1:0]  resp;
        logic        bsy;
        logic        rd;
        logic        dchk;
        logic        hit;
        logic [31:0] w0;
    } vec_t;

    vec_t tbl [9];
    logic [1:0] exp_seq [4];

    initial begin
        logic [1:0] a;
        logic [1:0] r;
        int         lat;
        int         n;
        int         rd0;
        int         wr0;

        // Single read from requester 0 at 0x40, one row per cycle.
        tbl[0] = '{2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[2] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[3] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[4] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[5] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[6] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[7] = '{2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1000};
        tbl[8] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        exp_seq[0] = 2'b01;
        exp_seq[1] = 2'b10;
        exp_seq[2] = 2'b01;
        exp_seq[3] = 2'b10;

        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("reset_ack",     64'(bus.req_ack), 64'd0);
        chk("reset_resp",    64'(bus.resp_valid), 64'd0);
        chk("reset_busy",    64'(busy), 64'd0);
        chk("reset_terr",    64'(timeout_err), 64'd0);
        chk("reset_rd",      64'(bus.l2_cache_read), 64'd0);
        chk("reset_wr",      64'(bus.l2_cache_write), 64'd0);
        chk("reset_addr",    64'(bus.l2_cache_addr), 64'd0);
        chk("reset_rdata",   64'(|bus.resp_rdata), 64'd0);

        // Test 1: table-driven single read.
        bus.req_addr[0 +: AW] = 32'h40;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t1_ack[%0d]", i),  64'(bus.req_ack), 64'(tbl[i].ack));
            chk($sformatf("t1_resp[%0d]", i), 64'(bus.resp_valid), 64'(tbl[i].resp));
            chk($sformatf("t1_busy[%0d]", i), 64'(busy), 64'(tbl[i].bsy));
            chk($sformatf("t1_rd[%0d]", i),   64'(bus.l2_cache_read), 64'(tbl[i].rd));
            if (tbl[i].dchk) begin
                chk($sformatf("t1_w0[%0d]", i),  64'(bus.resp_rdata[31:0]), 64'(tbl[i].w0));
                chk($sformatf("t1_hit[%0d]", i), 64'(bus.resp_hit), 64'(tbl[i].hit));
            end
            bus.req_valid = tbl[i].rv;
            @(negedge clk);
        end

        // Test 6: ready already high on ISSUE entry, hit path, single strobe.
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        run_txn(0, 1'b0, 32'hC0, a, r, lat);
        chk("t6_ack", 64'(a), 64'd1);
        chk("t6_resp", 64'(r), 64'd1);
        chk("t6_latency", 64'(lat), 64'd7);
        chk("t6_rd_pulses", 64'(rd_pulses - rd0), 64'd1);
        chk("t6_wr_pulses", 64'(wr_pulses - wr0), 64'd0);
        chk("t6_w0", 64'(bus.resp_rdata[31:0]), 64'h3000);
        chk("t6_w3", 64'(bus.resp_rdata[3*DW +: DW]), 64'h3003);
        chk("t6_hit", 64'(bus.resp_hit), 64'd1);

        // Test 4: L2 ready stuck low after the strobe.
        bus.req_write[0]    = 1'b0;
        bus.req_addr[0 +: AW] = 32'h40;
        bus.req_valid[0]    = 1'b1;
        n = 0;
        while (n < 20 && bus.req_ack == 2'b00) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid[0] = 1'b0;
        n = 0;
        while (n < 20 && !bus.l2_cache_read) begin
            @(negedge clk);
            n++;
        end
        chk("t4_strobe_seen", 64'(bus.l2_cache_read), 64'd1);
        stuck = 1'b1;
        n = 0;
        while (n < 40 && !timeout_err) begin
            @(negedge clk);
            n++;
            if (!timeout_err) begin
                chk("t4_no_early_resp", 64'(bus.resp_valid), 64'd0);
            end
        end
        chk("t4_wait_cycles", 64'(n), 64'(TMO));
        chk("t4_terr", 64'(timeout_err), 64'd1);
        chk("t4_resp", 64'(bus.resp_valid), 64'd1);
        chk("t4_hit", 64'(bus.resp_hit), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        stuck = 1'b0;
        @(negedge clk);
        chk("t4_terr_sticky", 64'(timeout_err), 64'd1);
        chk("t4_resp_pulse", 64'(bus.resp_valid), 64'd0);
        run_txn(1, 1'b0, 32'h140, a, r, lat);
        chk("t4_next_ack", 64'(a), 64'd2);
        chk("t4_next_resp", 64'(r), 64'd2);
        chk("t4_next_w0", 64'(bus.resp_rdata[31:0]), 64'h5000);
        chk("t4_next_hit", 64'(bus.resp_hit), 64'd1);

        // Test 3: write-back from requester 1.
        for (int j = 0; j < BW; j++) begin
            bus.req_wdata[BLKB + j*DW +: DW] = 32'hA000_0000 + 32'(j);
        end
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        run_txn(1, 1'b1, 32'h80, a, r, lat);
        chk("t3_ack", 64'(a), 64'd2);
        chk("t3_resp", 64'(r), 64'd2);
        chk("t3_wr_pulses", 64'(wr_pulses - wr0), 64'd1);
        chk("t3_rd_pulses", 64'(rd_pulses - rd0), 64'd0);
        chk("t3_w5_at_strobe", 64'(cap_w5), 64'hA000_0005);
        chk("t3_w5_at_resp", 64'(bus.l2_cache_data_in[5*DW +: DW]), 64'hA000_0005);
        chk("t3_addr_at_resp", 64'(bus.l2_cache_addr), 64'h80);
        chk("t3_hit", 64'(bus.resp_hit), 64'd0);

        // Test 2: both requesters pending from reset, grants must alternate.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("t2_terr_cleared", 64'(timeout_err), 64'd0);
        bus.req_write = 2'b00;
        bus.req_addr[0 +: AW]  = 32'h100;
        bus.req_addr[AW +: AW] = 32'h140;
        bus.req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            a = 2'b00;
            while (n < 20 && a == 2'b00) begin
                @(negedge clk);
                n++;
                a = bus.req_ack;
            end
            chk($sformatf("t2_ack[%0d]", t), 64'(a), 64'(exp_seq[t]));
            n = 0;
            r = 2'b00;
            while (n < 40 && r == 2'b00) begin
                @(negedge clk);
                n++;
                r = bus.resp_valid;
            end
            chk($sformatf("t2_resp[%0d]", t), 64'(r), 64'(exp_seq[t]));
            chk($sformatf("t2_w0[%0d]", t), 64'(bus.resp_rdata[31:0]),
                (t % 2 == 0) ? 64'h4000 : 64'h5000);
        end
        bus.req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("t2_idle_after", 64'(busy), 64'd0);

        // Test 5: reset in WAIT_HI with requester 1 pending.
        bus.req_addr[0 +: AW] = 32'h40;
        bus.req_valid[0] = 1'b1;
        n = 0;
        while (n < 20 && bus.req_ack == 2'b00) begin
            @(negedge clk);
            n++;
        end
        chk("t5_first_ack", 64'(bus.req_ack), 64'd1);
        bus.req_valid = 2'b10;
        n = 0;
        while (n < 20 && !bus.l2_cache_read) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("t5_busy_before", 64'(busy), 64'd1);
        chk("t5_resp_before", 64'(bus.resp_valid), 64'd0);
        rst = 1'b1;
        #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_rd", 64'(bus.l2_cache_read | bus.l2_cache_write), 64'd0);
        chk("t5_ack", 64'(bus.req_ack), 64'd0);
        chk("t5_resp", 64'(bus.resp_valid), 64'd0);
        chk("t5_addr", 64'(bus.l2_cache_addr), 64'd0);
        chk("t5_rdata", 64'(|bus.resp_rdata), 64'd0);
        chk("t5_hit", 64'(bus.resp_hit), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_regrant", 64'(bus.req_ack), 64'd2);
        bus.req_valid = 2'b00;
        n = 0;
        r = 2'b00;
        while (n < 40 && r == 2'b00) begin
            @(negedge clk);
            n++;
            r = bus.resp_valid;
        end
        chk("t5_resp_after", 64'(r), 64'd2);
        chk("t5_w0_after", 64'(bus.resp_rdata[31:0]), 64'h5000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
